rx_arbiter: RTL

Round-robin arbiter that shares one downstream consumer (router crossbar/output `tx` path) between `NPORTS` `rx` deserializers. Each `rx` holds a complete item with `valid` high until it sees a one-cycle `item_read` pulse. This block picks one valid port, presents its item downstream, and on acceptance pulses that port's `item_read` so the `rx` returns to idle. Fairness is strict round-robin starting after the last served port.

---
 rtl/rx_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rx_arbiter.sv
// Round-robin arbiter sharing one downstream consumer between NPORTS rx deserializers.
// Define RX_ARB_REG_OUT_EN to source out_item from a register captured at grant time.

`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module rx_arbiter #(
    parameter int NPORTS   = 5,
    parameter int ROUTERID = -1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [NPORTS-1:0]                              rx_valid,
    input  logic [NPORTS*(`PAYLOAD_SIZE+`ADDR_BITS)-1:0]   rx_item,
    output logic [NPORTS-1:0]                              rx_read,
    output logic [NPORTS-1:0]                              grant,
    output logic                                           out_valid,
    output logic [(`PAYLOAD_SIZE+`ADDR_BITS)-1:0]          out_item,
    input  logic                                           out_ready
);

    localparam int W  = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     ptr_reg, ptr_next;
    logic [PW-1:0]     gidx_reg, gidx_next;
    logic [NPORTS-1:0] grant_reg, grant_next;
    logic [NPORTS-1:0] rx_read_reg, rx_read_next;

    logic              win_found;
    logic [PW-1:0]     win_idx;

    // ROUTERID only labels simulation messages; it has no hardware effect.
    if (ROUTERID < -1) begin : g_id_unused
    end

    // Scan from the highest offset down so the port closest to ptr is kept last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            logic [PW-1:0] cand;
            cand = PW'((int'(ptr_reg) + i) % NPORTS);
            if (rx_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gidx_reg    <= '0;
            grant_reg   <= '0;
            rx_read_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gidx_reg    <= gidx_next;
            grant_reg   <= grant_next;
            rx_read_reg <= rx_read_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gidx_next    = gidx_reg;
        grant_next   = grant_reg;
        rx_read_next = '0;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next = SEND;
                    gidx_next  = win_idx;
                    grant_next = {{(NPORTS-1){1'b0}}, 1'b1} << win_idx;
                end
            end
            SEND: begin
                if (out_ready) begin
                    state_next   = DONE;
                    rx_read_next = grant_reg;
                    ptr_next     = (gidx_reg == PW'(NPORTS - 1)) ? '0 : gidx_reg + 1'b1;
                end else if (!(|(rx_valid & grant_reg))) begin
                    // Requester withdrew before acceptance: release without acknowledging.
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant     = grant_reg;
    assign rx_read   = rx_read_reg;
    assign out_valid = (state_reg == SEND);

`ifdef RX_ARB_REG_OUT_EN
    logic [W-1:0] win_masked [NPORTS];
    logic [W-1:0] win_item;
    logic [W-1:0] item_reg;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_win_mask
        assign win_masked[gi] = rx_item[gi*W +: W] & {W{win_idx == PW'(gi)}};
    end

    always_comb begin
        win_item = '0;
        for (int p = 0; p < NPORTS; p++) begin
            win_item = win_item | win_masked[p];
        end
    end

    // Cleared on any exit from SEND so out_item reads 0 whenever nothing is offered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            item_reg <= '0;
        end else if (state_reg == IDLE && win_found) begin
            item_reg <= win_item;
        end else if (state_reg == SEND && state_next != SEND) begin
            item_reg <= '0;
        end
    end

    assign out_item = item_reg;
`else
    logic [W-1:0] sel_masked [NPORTS];
    logic [W-1:0] sel_item;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_sel_mask
        assign sel_masked[gi] = rx_item[gi*W +: W] & {W{grant_reg[gi]}};
    end

    always_comb begin
        sel_item = '0;
        for (int p = 0; p < NPORTS; p++) begin
            sel_item = sel_item | sel_masked[p];
        end
    end

    assign out_item = (state_reg == SEND) ? sel_item : '0;
`endif

endmodule
